// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb3_rr.sv
// Three-requester round-robin arbiter with bounded grant tenure.
// Z is the combinational OR3 "any request" term; grants are registered and one-hot.
module gf180mcu_fd_sc_mcu9t5v0__arb3_rr #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic CLK,
   input  logic RN,
   input  logic A1,
   input  logic A2,
   input  logic A3,
   output logic G1,
   output logic G2,
   output logic G3,
   output logic Z,
   output logic BUSY
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   localparam logic [3:0] HOLD_CNT = 4'(HOLD_MAX);

   logic [0:0] state, state_nxt;
   logic [1:0] last, last_nxt;     // requester index 1..3, never 0 outside reset
   logic [3:0] cnt, cnt_nxt;
   logic [2:0] gnt, gnt_nxt;
   logic [2:0] req, others;
   logic       own_req;

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      case (idx)
         2'd1:    onehot = 3'b001;
         2'd2:    onehot = 3'b010;
         2'd3:    onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      next_idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
   endfunction

   // First requester in the order last+1, last+2, last.
   function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [2:0] r);
      logic [1:0] c1, c2;
      c1 = next_idx(from);
      c2 = next_idx(c1);
      if (|(r & onehot(c1)))      rr_pick = c1;
      else if (|(r & onehot(c2))) rr_pick = c2;
      else                        rr_pick = from;
   endfunction

   assign req     = {A3, A2, A1};
   assign Z       = A1 | A2 | A3;
   assign others  = req & ~onehot(last);
   assign own_req = |(req & onehot(last));

   // NOTE: every next-state variable gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               last_nxt  = rr_pick(last, req);
               cnt_nxt   = 4'd1;
            end
         end
         GRANT: begin
            // In GRANT the owner is always last; masking it out leaves the handoff candidates.
            if (!own_req || ((|others) && (cnt == HOLD_CNT))) begin
               if (|others) begin
                  last_nxt = rr_pick(last, others);
                  cnt_nxt  = 4'd1;
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = 4'd0;
               end
            end else if (cnt != HOLD_CNT) begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      gnt_nxt = (state_nxt == GRANT) ? onehot(last_nxt) : 3'b000;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         state <= IDLE;
         last  <= 2'd3;
         cnt   <= 4'd0;
         gnt   <= 3'b000;
         BUSY  <= 1'b0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         BUSY  <= (state_nxt == GRANT);
      end
   end

   assign G1 = gnt[0];
   assign G2 = gnt[1];
   assign G3 = gnt[2];

endmodule
